// File: rtl/cdc_sched_pkg.sv
// rtl/cdc_sched_pkg.sv - shared types, defaults and helpers for the CDC handshake scheduler
package cdc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } sched_state_t;

  localparam int DEF_N_REQ          = 4;
  localparam int DEF_D_BITWIDTH     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // Pointer/index width; at least one bit so a 1-wide field is never zero-sized.
  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter with double-width wrap mask
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  valid_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  win_onehot_o,
  output logic [PW-1:0] win_idx_o,
  output logic          win_any_o
);

  logic [N-1:0]   hi_mask;
  logic [2*N-1:0] dbl;

  // Lower half holds requesters at or above the pointer, upper half all of them,
  // so the lowest set bit of the doubled vector is the next requester in ring order.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = (i >= int'(ptr_i));
    end
    dbl = {valid_i, valid_i & hi_mask};
  end

  // Priority-scan the doubled vector and fold the position back into 0..N-1.
  always_comb begin
    int pos;
    pos          = 0;
    win_idx_o    = '0;
    win_onehot_o = '0;
    win_any_o    = |valid_i;
    for (int j = 2 * N - 1; j >= 0; j--) begin
      if (dbl[j]) begin
        pos = j;
      end
    end
    if (pos >= N) begin
      pos = pos - N;
    end
    win_idx_o = pos[PW-1:0];
    if (win_any_o) begin
      win_onehot_o[win_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/cdc_handshake_scheduler.sv
// rtl/cdc_handshake_scheduler.sv - shares one req/ack CDC channel among N_REQ requesters (option: CDC_SCHED_TIMEOUT_EN)
module cdc_handshake_scheduler
  import cdc_sched_pkg::*;
#(
  parameter int N_REQ        = DEF_N_REQ,
  parameter int P_D_BITWIDTH = DEF_D_BITWIDTH
`ifdef CDC_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic                            ICLK,
  input  logic                            RST_N_ICLK,
  input  logic [N_REQ-1:0]                REQ_VALID,
  input  logic [N_REQ*P_D_BITWIDTH-1:0]   REQ_DATA,
  output logic [N_REQ-1:0]                REQ_GRANT,
  output logic [N_REQ-1:0]                REQ_DONE,
  output logic                            CH_SEND_EN,
  output logic [P_D_BITWIDTH-1:0]         CH_DATA,
  input  logic                            CH_DONE,
  output logic                            BUSY
`ifdef CDC_SCHED_TIMEOUT_EN
  ,
  output logic                            ERR_TIMEOUT
`endif
);

  localparam int PW = ptr_width(N_REQ);

  sched_state_t            state_q, state_d;
  logic [P_D_BITWIDTH-1:0] ch_data_q, ch_data_d;
  logic [N_REQ-1:0]        owner_q, owner_d;
  logic [PW-1:0]           ptr_q, ptr_d;

  logic [N_REQ-1:0]        win_onehot;
  logic [PW-1:0]           win_idx;
  logic                    win_any;
  logic [P_D_BITWIDTH-1:0] win_data;
  logic [PW-1:0]           ptr_next;

`ifdef CDC_SCHED_TIMEOUT_EN
  logic [31:0]             cnt_q, cnt_d;
  logic                    tmo_q, tmo_d;
`endif

  rr_arbiter #(
    .N  (N_REQ),
    .PW (PW)
  ) u_arb (
    .valid_i      (REQ_VALID),
    .ptr_i        (ptr_q),
    .win_onehot_o (win_onehot),
    .win_idx_o    (win_idx),
    .win_any_o    (win_any)
  );

  // Select the winner's payload and the pointer slot just past the winner.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_onehot[i]) begin
        win_data = win_data | REQ_DATA[i*P_D_BITWIDTH +: P_D_BITWIDTH];
      end
    end
    ptr_next = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
  end

  // Next-state logic: arbitrate in IDLE, hold the channel through SEND/WAIT, drop it in GAP.
  always_comb begin
    state_d   = state_q;
    ch_data_d = ch_data_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
`ifdef CDC_SCHED_TIMEOUT_EN
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_any) begin
          ch_data_d = win_data;
          owner_d   = win_onehot;
          ptr_d     = ptr_next;
          state_d   = SEND;
        end
      end
      SEND: begin
        state_d = WAIT;
`ifdef CDC_SCHED_TIMEOUT_EN
        cnt_d   = '0;
        tmo_d   = 1'b0;
`endif
      end
      WAIT: begin
        if (CH_DONE) begin
          state_d = GAP;
`ifdef CDC_SCHED_TIMEOUT_EN
        end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          state_d = GAP;
          tmo_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 32'd1;
`endif
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge ICLK or negedge RST_N_ICLK) begin
    if (!RST_N_ICLK) begin
      state_q   <= IDLE;
      ch_data_q <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
`ifdef CDC_SCHED_TIMEOUT_EN
      cnt_q     <= '0;
      tmo_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ch_data_q <= ch_data_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
`ifdef CDC_SCHED_TIMEOUT_EN
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
`endif
    end
  end

  // Outputs decode directly from state so reset clears them in the same cycle.
  always_comb begin
    REQ_GRANT  = (state_q == SEND) ? owner_q : '0;
    CH_SEND_EN = (state_q == SEND) || (state_q == WAIT);
    CH_DATA    = ch_data_q;
    BUSY       = (state_q != IDLE);
`ifdef CDC_SCHED_TIMEOUT_EN
    REQ_DONE    = ((state_q == GAP) && !tmo_q) ? owner_q : '0;
    ERR_TIMEOUT = (state_q == GAP) && tmo_q;
`else
    REQ_DONE    = (state_q == GAP) ? owner_q : '0;
`endif
  end

endmodule
